// File: rtl/round_key_sequencer.sv
// -----------------------------------------------------------------------------
// round_key_sequencer
//
// Holds the AES-256 round-key schedule produced by key expansion and replays it,
// one 128-bit round key per beat, to the iterative cipher round datapath.
// A shadow bank lets a new schedule arrive while a block is being served. The
// shadow is promoted into the active bank only at the final beat, so the block
// in flight always sees one consistent schedule.
//
// Ports
//   clk           rising-edge clock for all state
//   reset         asynchronous, active-low; clears all control state at once
//   cipher_key    original 256-bit key: round key 0 = [255:128], 1 = [127:0]
//   key_expan     NUM_GEN generated subkeys; subkey k feeds round key k+2
//   key_valid_in  single-cycle strobe qualifying cipher_key/key_expan
//   start         single-cycle request to stream a schedule for a new block
//   rk_out        current round key (zero whenever rk_valid is low)
//   rk_idx        index 0..NUMS_OF_ROUND of rk_out
//   rk_valid      rk_out/rk_idx valid
//   rk_ready      consumer accepts the beat when rk_valid && rk_ready
//   rk_last       high with rk_valid on the final round key
//   key_loaded    an active schedule is held
//   key_pending   a shadow schedule is waiting to be promoted
//   start_err     single-cycle pulse: a start was rejected
//
// Every output is decoded from registers only; rk_ready, start and
// key_valid_in never reach an output combinationally.
// -----------------------------------------------------------------------------
module round_key_sequencer #(
  parameter int KEY_LEN       = 128,
  parameter int NUM_GEN       = 13,
  parameter int NUMS_OF_ROUND = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*KEY_LEN-1:0]       cipher_key,
  input  logic [NUM_GEN*KEY_LEN-1:0] key_expan,
  input  logic                       key_valid_in,
  input  logic                       start,
  output logic [KEY_LEN-1:0]         rk_out,
  output logic [3:0]                 rk_idx,
  output logic                       rk_valid,
  input  logic                       rk_ready,
  output logic                       rk_last,
  output logic                       key_loaded,
  output logic                       key_pending,
  output logic                       start_err
);

  localparam int         NUM_KEYS = NUMS_OF_ROUND + 1;
  localparam logic [3:0] LAST_IDX = 4'(NUMS_OF_ROUND);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic       pending_reg, pending_next;
  logic       start_err_reg, start_err_next;

  logic [KEY_LEN-1:0] in_keys     [NUM_KEYS];
  logic [KEY_LEN-1:0] active_bank [NUM_KEYS];
  logic [KEY_LEN-1:0] shadow_bank [NUM_KEYS];

  logic load_active_in;
  logic load_active_shadow;
  logic load_shadow;
  logic handshake;
  logic final_beat;

  // Flatten the expansion outputs into round-key order.
  assign in_keys[0] = cipher_key[2*KEY_LEN-1:KEY_LEN];
  assign in_keys[1] = cipher_key[KEY_LEN-1:0];

  generate
    for (genvar gi = 0; gi < NUM_GEN; gi++) begin : g_in_keys
      assign in_keys[gi+2] = key_expan[gi*KEY_LEN +: KEY_LEN];
    end
  endgenerate

  assign handshake  = (state_reg == STREAM) && rk_ready;
  assign final_beat = handshake && (idx_reg == LAST_IDX);

  // Key banks carry no reset: their contents are meaningless until a
  // key_valid_in moves the FSM out of EMPTY, and rk_out is gated anyway.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (load_active_in) begin
        active_bank[i] <= in_keys[i];
      end else if (load_active_shadow) begin
        active_bank[i] <= shadow_bank[i];
      end
      if (load_shadow) begin
        shadow_bank[i] <= in_keys[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= EMPTY;
      idx_reg       <= '0;
      pending_reg   <= 1'b0;
      start_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      pending_reg   <= pending_next;
      start_err_reg <= start_err_next;
    end
  end

  // Next-state and bank-write control.
  always_comb begin
    state_next         = state_reg;
    idx_next           = idx_reg;
    pending_next       = pending_reg;
    start_err_next     = 1'b0;
    load_active_in     = 1'b0;
    load_active_shadow = 1'b0;
    load_shadow        = 1'b0;

    case (state_reg)
      EMPTY: begin
        // A start coinciding with the first key is still refused: there was
        // no schedule when the request was made.
        if (key_valid_in) begin
          load_active_in = 1'b1;
          state_next     = READY;
        end
        if (start) begin
          start_err_next = 1'b1;
        end
      end

      READY: begin
        // Loading and starting together is safe: beat 0 is read from the
        // bank one cycle later, after the new key has landed.
        if (key_valid_in) begin
          load_active_in = 1'b1;
        end
        if (start) begin
          state_next = STREAM;
          idx_next   = '0;
        end
      end

      STREAM: begin
        if (start) begin
          start_err_next = 1'b1;
        end
        if (final_beat) begin
          state_next   = READY;
          idx_next     = '0;
          pending_next = 1'b0;
          // A key arriving right now is newer than anything in the shadow.
          if (key_valid_in) begin
            load_active_in = 1'b1;
          end else if (pending_reg) begin
            load_active_shadow = 1'b1;
          end
        end else begin
          if (handshake) begin
            idx_next = idx_reg + 4'd1;
          end
          if (key_valid_in) begin
            load_shadow  = 1'b1;
            pending_next = 1'b1;
          end
        end
      end

      default: begin
        state_next   = EMPTY;
        idx_next     = '0;
        pending_next = 1'b0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    rk_valid    = (state_reg == STREAM);
    rk_idx      = idx_reg;
    rk_last     = rk_valid && (idx_reg == LAST_IDX);
    rk_out      = rk_valid ? active_bank[idx_reg] : '0;
    key_loaded  = (state_reg != EMPTY);
    key_pending = pending_reg;
    start_err   = start_err_reg;
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
module tb_round_key_sequencer;

  localparam int KEY_LEN       = 128;
  localparam int NUM_GEN       = 13;
  localparam int NUMS_OF_ROUND = 14;
  localparam int NK            = NUMS_OF_ROUND + 1;

  typedef logic [NK-1:0][KEY_LEN-1:0] sched_t;

  typedef struct {
    bit         kv;
    bit         st;
    bit         rdy;
    bit         e_valid;
    logic [3:0] e_idx;
    bit         e_last;
    bit         e_err;
    bit         e_loaded;
    bit         e_pending;
    int         e_key;   // round key index of the FIPS schedule, -1 = zero
  } vec_t;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic [2*KEY_LEN-1:0]       cipher_key = '0;
  logic [NUM_GEN*KEY_LEN-1:0] key_expan = '0;
  logic                       key_valid_in = 1'b0;
  logic                       start = 1'b0;
  logic [KEY_LEN-1:0]         rk_out;
  logic [3:0]                 rk_idx;
  logic                       rk_valid;
  logic                       rk_ready = 1'b0;
  logic                       rk_last;
  logic                       key_loaded;
  logic                       key_pending;
  logic                       start_err;

  int total_cnt = 0;
  int pass_cnt  = 0;

  sched_t cur_in;
  sched_t fips_s, key_b, key_c;
  logic [KEY_LEN-1:0] got_beats [NK];

  // Reference model state: schedule abstraction plus a queue of beats still owed.
  bit                 m_loaded;
  bit                 m_pending;
  bit                 m_err;
  sched_t             m_active;
  sched_t             m_shadow;
  logic [KEY_LEN-1:0] m_q [$];

  always #5 clk = ~clk;

  round_key_sequencer #(
    .KEY_LEN(KEY_LEN), .NUM_GEN(NUM_GEN), .NUMS_OF_ROUND(NUMS_OF_ROUND)
  ) dut (
    .clk(clk), .reset(reset), .cipher_key(cipher_key), .key_expan(key_expan),
    .key_valid_in(key_valid_in), .start(start), .rk_out(rk_out), .rk_idx(rk_idx),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last),
    .key_loaded(key_loaded), .key_pending(key_pending), .start_err(start_err)
  );

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [KEY_LEN-1:0] act, input logic [KEY_LEN-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // ---------------- AES-256 key expansion (FIPS-197) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic sched_t expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    sched_t      s;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < NK; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  function automatic sched_t rand_sched();
    sched_t s;
    for (int r = 0; r < NK; r++)
      for (int w = 0; w < 4; w++) s[r][32*w +: 32] = $urandom;
    return s;
  endfunction

  task automatic drive_sched(input sched_t s);
    cur_in     = s;
    cipher_key = {s[0], s[1]};
    key_expan  = s[NK-1:2];
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_loaded  = 1'b0;
    m_pending = 1'b0;
    m_err     = 1'b0;
    m_q.delete();
  endtask

  task automatic model_check();
    int n;
    logic [KEY_LEN-1:0] e_out;
    n     = m_q.size();
    e_out = (n != 0) ? m_q[0] : '0;
    chk("m_valid",   rk_valid,    n != 0);
    chk("m_idx",     rk_idx,      (n != 0) ? NK - n : 0);
    chk("m_out",     rk_out,      e_out);
    chk("m_last",    rk_last,     n == 1);
    chk("m_err",     start_err,   m_err);
    chk("m_loaded",  key_loaded,  m_loaded);
    chk("m_pending", key_pending, m_pending);
  endtask

  task automatic model_step();
    bit fin;
    sched_t src;
    if (!reset) begin
      model_reset();
      return;
    end
    m_err = 1'b0;
    if (m_q.size() == 0) begin
      if (start && m_loaded) begin
        src = key_valid_in ? cur_in : m_active;
        for (int r = 0; r < NK; r++) m_q.push_back(src[r]);
      end else if (start) begin
        m_err = 1'b1;
      end
      if (key_valid_in) begin
        m_active = cur_in;
        m_loaded = 1'b1;
      end
    end else begin
      fin = rk_ready && (m_q.size() == 1);
      if (start) m_err = 1'b1;
      if (rk_ready) void'(m_q.pop_front());
      if (fin) begin
        if (key_valid_in) m_active = cur_in;
        else if (m_pending) m_active = m_shadow;
        m_pending = 1'b0;
      end else if (key_valid_in) begin
        m_shadow  = cur_in;
        m_pending = 1'b1;
      end
    end
  endtask

  // One clock: compare against the model mid-cycle, advance on the edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Serve a stream to completion. mode 0: ready high, 1: 1,0,0 pattern,
  // 2: random ready. rekey_at >= 0 pulses key_valid_in with new_s when
  // rk_idx first shows that index.
  task automatic run_stream(input sched_t exp_s, input int first_idx, input int mode,
                            input int rekey_at, input sched_t new_s,
                            output int n_beats, output int n_cycles);
    int nxt;
    bit done;
    bit rekeyed;
    bit stall;
    bit rk_now;
    logic [KEY_LEN-1:0] held_out;
    logic [3:0] held_idx;
    nxt = first_idx;
    done = 1'b0;
    rekeyed = 1'b0;
    n_beats = 0;
    n_cycles = 0;
    while (!done && n_cycles < 200) begin
      case (mode)
        0:       rk_ready = 1'b1;
        1:       rk_ready = (n_cycles % 3) == 0;
        default: rk_ready = 1'($urandom_range(0, 1));
      endcase
      rk_now = 1'b0;
      if (!rekeyed && rk_valid && rekey_at >= 0 && int'(rk_idx) == rekey_at) begin
        drive_sched(new_s);
        key_valid_in = 1'b1;
        rekeyed = 1'b1;
        rk_now = 1'b1;
      end
      stall    = rk_valid && !rk_ready;
      held_out = rk_out;
      held_idx = rk_idx;
      if (rk_valid && rk_ready) begin
        chk("beat_idx",  rk_idx,  nxt);
        chk("beat_key",  rk_out,  exp_s[nxt]);
        chk("beat_last", rk_last, nxt == NK - 1);
        if (nxt < NK) got_beats[nxt] = rk_out;
        if (nxt == NK - 1) done = 1'b1;
        nxt++;
        n_beats++;
      end
      tick();
      n_cycles++;
      key_valid_in = 1'b0;
      if (stall) begin
        chk("stall_out", rk_out, held_out);
        chk("stall_idx", rk_idx, held_idx);
      end
      if (rk_now) chk("pending_after_rekey", key_pending, !done);
    end
    rk_ready = 1'b0;
    chk("stream_done", done, 1'b1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ok_err", start_err, 1'b0);
    chk("start_ok_valid", rk_valid, 1'b1);
    chk("start_ok_idx", rk_idx, 0);
  endtask

  vec_t tbl [10];

  initial begin
    int nb;
    int nc;
    logic [KEY_LEN-1:0] exp_k;

    fips_s = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    key_b  = expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    key_c  = rand_sched();
    drive_sched(fips_s);
    model_reset();

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rk_valid, 1'b0);
    chk("rst_out", rk_out, '0);
    chk("rst_idx", rk_idx, 0);
    chk("rst_last", rk_last, 1'b0);
    chk("rst_loaded", key_loaded, 1'b0);
    chk("rst_pending", key_pending, 1'b0);
    chk("rst_err", start_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table-driven vectors ----------------
    //           kv st rdy  val idx last err ld pend key
    tbl[0] = '{0, 1, 0,    0, 0, 0, 1, 0, 0, -1};  // start in EMPTY
    tbl[1] = '{0, 0, 1,    0, 0, 0, 0, 0, 0, -1};
    tbl[2] = '{1, 0, 0,    0, 0, 0, 0, 1, 0, -1};  // load FIPS key
    tbl[3] = '{0, 1, 0,    1, 0, 0, 0, 1, 0,  0};  // start
    tbl[4] = '{0, 0, 0,    1, 0, 0, 0, 1, 0,  0};  // stalled
    tbl[5] = '{0, 0, 1,    1, 1, 0, 0, 1, 0,  1};
    tbl[6] = '{0, 1, 1,    1, 2, 0, 1, 1, 0,  2};  // start mid-stream
    tbl[7] = '{0, 0, 0,    1, 2, 0, 0, 1, 0,  2};
    tbl[8] = '{0, 0, 0,    1, 2, 0, 0, 1, 0,  2};
    tbl[9] = '{0, 0, 1,    1, 3, 0, 0, 1, 0,  3};
    for (int i = 0; i < 10; i++) begin
      key_valid_in = tbl[i].kv;
      start        = tbl[i].st;
      rk_ready     = tbl[i].rdy;
      tick();
      key_valid_in = 1'b0;
      start        = 1'b0;
      exp_k = (tbl[i].e_key < 0) ? '0 : fips_s[tbl[i].e_key];
      chk($sformatf("vec%0d_valid", i),   rk_valid,    tbl[i].e_valid);
      chk($sformatf("vec%0d_idx", i),     rk_idx,      tbl[i].e_idx);
      chk($sformatf("vec%0d_last", i),    rk_last,     tbl[i].e_last);
      chk($sformatf("vec%0d_err", i),     start_err,   tbl[i].e_err);
      chk($sformatf("vec%0d_loaded", i),  key_loaded,  tbl[i].e_loaded);
      chk($sformatf("vec%0d_pending", i), key_pending, tbl[i].e_pending);
      chk($sformatf("vec%0d_out", i),     rk_out,      exp_k);
    end

    // Finish the first stream under 1,0,0 backpressure.
    run_stream(fips_s, 3, 1, -1, fips_s, nb, nc);
    chk("bp_beats", nb, NK - 3);

    // Back-to-back stream with ready held high: exact timing and FIPS values.
    do_start();
    run_stream(fips_s, 0, 0, -1, fips_s, nb, nc);
    chk("full_beats", nb, NK);
    chk("full_cycles", nc, NK);
    chk("after_last_valid", rk_valid, 1'b0);
    chk("after_last_out", rk_out, '0);
    chk("fips_rk0",  got_beats[0],  128'h000102030405060708090a0b0c0d0e0f);
    chk("fips_rk1",  got_beats[1],  128'h101112131415161718191a1b1c1d1e1f);
    chk("fips_rk2",  got_beats[2],  128'ha573c29fa176c498a97fce93a572c09c);
    chk("fips_rk14", got_beats[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Mid-stream rekey at beat 5; stream keeps key A, next stream uses B.
    do_start();
    run_stream(fips_s, 0, 2, 5, key_b, nb, nc);
    chk("rekey_pending_clear", key_pending, 1'b0);
    do_start();
    chk("rekey_b_idx0", rk_out, key_b[0]);
    // Rekey coinciding with the final handshake.
    run_stream(key_b, 0, 0, NK - 1, key_c, nb, nc);
    chk("final_rekey_pending", key_pending, 1'b0);
    do_start();
    chk("rekey_c_idx0", rk_out, key_c[0]);
    run_stream(key_c, 0, 1, -1, key_c, nb, nc);

    // Reset at beat 7 with a shadow pending.
    do_start();
    rk_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        drive_sched(key_b);
        key_valid_in = 1'b1;
      end
      tick();
      key_valid_in = 1'b0;
    end
    chk("pre_rst_idx", rk_idx, 7);
    chk("pre_rst_pending", key_pending, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", rk_valid, 1'b0);
    chk("mid_rst_out", rk_out, '0);
    chk("mid_rst_idx", rk_idx, 0);
    chk("mid_rst_last", rk_last, 1'b0);
    chk("mid_rst_loaded", key_loaded, 1'b0);
    chk("mid_rst_pending", key_pending, 1'b0);
    tick();
    reset = 1'b1;
    rk_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("post_rst_err", start_err, 1'b1);
      chk("post_rst_valid", rk_valid, 1'b0);
      tick();
      chk("post_rst_err_drop", start_err, 1'b0);
    end
    drive_sched(key_c);
    key_valid_in = 1'b1;
    tick();
    key_valid_in = 1'b0;
    do_start();
    chk("post_rst_key", rk_out, key_c[0]);

    // ---------------- randomized run against the model ----------------
    for (int c = 0; c < 3000; c++) begin
      key_valid_in = ($urandom_range(0, 9) == 0);
      if (key_valid_in) drive_sched(rand_sched());
      start    = ($urandom_range(0, 7) == 0);
      rk_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        #2;
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end
    key_valid_in = 1'b0;
    start = 1'b0;
    rk_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
# round_key_sequencer

Buffers the AES-256 round-key schedule produced by the key-expansion pipeline and serves it, one 128-bit round key per beat, to the iterative cipher round datapath. It sits directly downstream of key expansion. It captures the original cipher key together with the 13 generated subkeys when the last expansion stage signals valid. It replays round keys 0..14 on a valid/ready stream for every block the cipher starts. A shadow buffer accepts a new schedule mid-stream without corrupting the block in flight.

## Interface
- KEY_LEN, 128, round-key width in bits
- NUM_GEN, 13, subkeys generated by key expansion
- NUMS_OF_ROUND, 14, AES-256 rounds; round keys served = NUMS_OF_ROUND+1 = 15
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- cipher_key  in  2*KEY_LEN  original 256-bit key; round key 0 = [255:128], round key 1 = [127:0]
- key_expan  in  NUM_GEN*KEY_LEN  subkey k at [(k+1)*KEY_LEN-1 : k*KEY_LEN]; round key i (i≥2) = subkey i-2
- key_valid_in  in  1  one-cycle pulse; cipher_key and key_expan are valid this cycle (valid_out of final expansion stage)
- start  in  1  one-cycle request to stream a schedule for a new block
- rk_out  out  KEY_LEN  current round key
- rk_idx  out  4  index 0..14 of rk_out
- rk_valid  out  1  rk_out/rk_idx valid
- rk_ready  in  1  consumer accepts beat when rk_valid && rk_ready
- rk_last  out  1  high with rk_valid when rk_idx == 14
- key_loaded  out  1  an active schedule is held
- key_pending  out  1  shadow schedule waiting for swap
- start_err  out  1  one-cycle pulse: start rejected

## Operation
- Storage: active bank and shadow bank, 15 × KEY_LEN each; pending flag.
- States: EMPTY (no key), READY (key held, idle), STREAM (serving beats).
- EMPTY: key_valid_in loads active, goes to READY. start is rejected and pulses start_err.
- READY: key_valid_in loads active directly. start goes to STREAM with idx = 0. On simultaneous key_valid_in and start, the new key loads and the stream uses the new key.
- STREAM: rk_valid = 1, rk_out = active[idx], rk_last = (idx == 14). A handshake increments idx. Without a handshake, all outputs hold stable.
- STREAM, key_valid_in: writes shadow and sets pending. A later key_valid_in overwrites shadow; the last one wins. The active bank is never modified mid-stream.
- STREAM, start: rejected and pulses start_err. The stream is unaffected.
- Final handshake (idx == 14): goes to READY with idx = 0.
  - If key_valid_in occurs the same cycle, active is loaded from the inputs.
  - Otherwise, if pending, active is loaded from shadow.
  - Pending clears in both cases.
- rk_idx is 4 bits and never exceeds 14; no wrap within a stream.
- reset low, at any time including mid-stream:
  - state = EMPTY; idx, pending, key_loaded, rk_valid, rk_last, start_err = 0.
  - rk_out = 0, rk_idx = 0.
  - Banks need not be cleared, but rk_out is forced to 0 whenever rk_valid = 0.

## Timing
- Capture: key_valid_in at edge t; key_loaded = 1 after t.
- Stream start: start accepted at edge t; rk_valid = 1, rk_idx = 0 in cycle t+1.
- With rk_ready held high, beats 0..14 occupy cycles t+1..t+15. rk_last is high in cycle t+15. rk_valid = 0 in cycle t+16.
- Back-to-back: start is legal in the first READY cycle after the final handshake, giving 1 idle cycle between streams.
- start_err asserts in the cycle after the offending start, for 1 cycle.
- Swap: pending shadow is visible at rk_idx 0 of the next stream. key_pending falls in the cycle after the final handshake.
- No combinational path from rk_ready or start to any output; all outputs are registered.

## Test plan
- Reset, load, stream:
  - Stimulus: drive the FIPS-197 AES-256 key 000102…1f and its expanded subkeys, pulse key_valid_in, then start with rk_ready = 1.
  - Response: 15 consecutive beats.
    - idx 0 = 000102030405060708090a0b0c0d0e0f
    - idx 1 = 101112131415161718191a1b1c1d1e1f
    - idx 2 = a573c29fa176c498a97fce93a572c09c
    - idx 14 = 24fc79ccbf0979e9371ac23c6d68de36, with rk_last = 1
- Backpressure: rk_ready toggles 1,0,0,1,… → rk_out and rk_idx are stable while stalled; still exactly 15 beats in order.
- Mid-stream rekey:
  - Stimulus: key B arrives at beat 5 of a stream using key A.
  - Response: beats 5..14 remain key A; key_pending = 1; next stream idx 0 = key B.
  - Variant: rekey on the same cycle as the final handshake also yields key B on the next stream.
- Rejected starts: start in EMPTY and start mid-stream → start_err pulses once each; no rk_valid in EMPTY; the in-flight stream completes unchanged.
- Reset mid-stream: assert reset at beat 7 → all outputs 0 immediately and state EMPTY. A subsequent start pulses start_err until a new key_valid_in arrives.
